// File: rtl/match_controller.sv
// Match sequencing for a two-player reaction game: clear, countdown, play, hold, repeat until a winner.
// Define MATCH_CTRL_SEG_EN to drive the active-low score digits; otherwise both digits are blank.
module match_controller #(
  parameter int WINS_TO_MATCH = 3,
  parameter int COUNT_CYCLES  = 8,
  parameter int HOLD_CYCLES   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       left_win,
  input  logic       right_win,
  output logic       play_reset,
  output logic       play_enable,
  output logic [2:0] left_score,
  output logic [2:0] right_score,
  output logic       match_over,
  output logic [1:0] winner,
  output logic [6:0] hex_left,
  output logic [6:0] hex_right
);

  localparam int MAXC = (COUNT_CYCLES > HOLD_CYCLES) ? COUNT_CYCLES : HOLD_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(COUNT_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [2:0]    WINS      = 3'(WINS_TO_MATCH);

  typedef enum logic [2:0] {
    IDLE, CLEAR, COUNTDOWN, PLAY, ROUND_END, MATCH_OVER
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    ls_q, ls_d, rs_q, rs_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ls_q    <= '0;
      rs_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ls_q    <= ls_d;
      rs_q    <= rs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ls_d    = ls_q;
    rs_d    = rs_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          ls_d    = '0;
          rs_d    = '0;
        end
      end
      CLEAR: begin
        state_d = COUNTDOWN;
        cnt_d   = '0;
      end
      COUNTDOWN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = PLAY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PLAY: begin
        // A simultaneous pulse is a tie: the round ends but nobody scores.
        if (left_win || right_win) begin
          state_d = ROUND_END;
          cnt_d   = '0;
          if (left_win && !right_win && ls_q < WINS) ls_d = ls_q + 1'b1;
          if (right_win && !left_win && rs_q < WINS) rs_d = rs_q + 1'b1;
        end
      end
      ROUND_END: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = (ls_q == WINS || rs_q == WINS) ? MATCH_OVER : CLEAR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MATCH_OVER: begin
        if (start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign play_reset  = (state_q == IDLE) || (state_q == CLEAR);
  assign play_enable = (state_q == PLAY);
  assign match_over  = (state_q == MATCH_OVER);
  assign left_score  = ls_q;
  assign right_score = rs_q;

  always_comb begin
    winner = 2'b00;
    if (state_q == MATCH_OVER) begin
      if (ls_q == WINS)      winner = 2'b01;
      else if (rs_q == WINS) winner = 2'b10;
    end
  end

`ifdef MATCH_CTRL_SEG_EN
  // Segment order {g,f,e,d,c,b,a}, active low.
  function automatic logic [6:0] seg7(input logic [2:0] v);
    case (v)
      3'd0:    seg7 = 7'b1000000;
      3'd1:    seg7 = 7'b1111001;
      3'd2:    seg7 = 7'b0100100;
      3'd3:    seg7 = 7'b0110000;
      3'd4:    seg7 = 7'b0011001;
      3'd5:    seg7 = 7'b0010010;
      3'd6:    seg7 = 7'b0000010;
      default: seg7 = 7'b1111000;
    endcase
  endfunction

  assign hex_left  = seg7(ls_q);
  assign hex_right = seg7(rs_q);
`else
  assign hex_left  = 7'b1111111;
  assign hex_right = 7'b1111111;
`endif

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_match_controller;

  localparam int C = 8;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       reset, start, left_win, right_win;
  logic       play_reset, play_enable, match_over;
  logic [2:0] left_score, right_score;
  logic [1:0] winner;
  logic [6:0] hex_left, hex_right;

  match_controller #(.WINS_TO_MATCH(3), .COUNT_CYCLES(C), .HOLD_CYCLES(H)) dut (
    .clock(clk), .reset(reset), .start(start), .left_win(left_win), .right_win(right_win),
    .play_reset(play_reset), .play_enable(play_enable),
    .left_score(left_score), .right_score(right_score),
    .match_over(match_over), .winner(winner),
    .hex_left(hex_left), .hex_right(hex_right)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic [24:0] exp;
  } chk_t;

  chk_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] seg(input logic [2:0] v);
`ifdef MATCH_CTRL_SEG_EN
    logic [6:0] t [8];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};
    return t[v];
`else
    return (v > 3'd7) ? 7'h00 : 7'b1111111;
`endif
  endfunction

  wire [24:0] obs = {play_reset, play_enable, match_over, winner, left_score, right_score,
                     hex_left, hex_right};

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        n_vec++;
        if (q[i].cyc < cyc || obs !== q[i].exp) begin
          n_err++;
          $display("FAIL %s @cyc %0d: got pr/pe/mo/win/ls/rs/hl/hr=%b want %b",
                   q[i].name, cyc, obs, q[i].exp);
        end
        q.delete(i);
      end
    end
  end

  task automatic expect_at(input int off, input string name, input logic pr, input logic pe,
                           input logic mo, input logic [1:0] w, input logic [2:0] ls,
                           input logic [2:0] rs);
    chk_t c;
    c.cyc  = cyc + off;
    c.name = name;
    c.exp  = {pr, pe, mo, w, ls, rs, seg(ls), seg(rs)};
    q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From IDLE: pulse start, expect CLEAR, C countdown cycles, then PLAY; stray wins injected meanwhile.
  task automatic go_play();
    start = 1'b1;
    expect_at(1, "clear", 1, 0, 0, 2'b00, 0, 0);
    for (int k = 1; k <= C; k++) expect_at(1 + k, "countdown", 0, 0, 0, 2'b00, 0, 0);
    expect_at(C + 2, "play_en", 0, 1, 0, 2'b00, 0, 0);
    tick();
    start = 1'b0;
    for (int i = 0; i < C + 1; i++) begin
      left_win  = (i == 0) || (i == 3);
      right_win = (i == 5);
      tick();
    end
    left_win  = 1'b0;
    right_win = 1'b0;
  endtask

  // From PLAY: apply a win pattern, hold, then either a new countdown to PLAY or MATCH_OVER.
  task automatic play_round(input logic lw, input logic rw, input logic [2:0] ls,
                            input logic [2:0] rs, input logic last, input logic [1:0] w);
    left_win  = lw;
    right_win = rw;
    for (int i = 1; i <= H; i++) expect_at(i, "round_end", 0, 0, 0, 2'b00, ls, rs);
    if (last) begin
      expect_at(H + 1, "match_over", 0, 0, 1, w, ls, rs);
      tick();
      left_win  = 1'b0;
      right_win = 1'b0;
      repeat (H) tick();
    end else begin
      expect_at(H + 1, "clear_again", 1, 0, 0, 2'b00, ls, rs);
      for (int k = 1; k <= C; k++) expect_at(H + 1 + k, "countdown2", 0, 0, 0, 2'b00, ls, rs);
      expect_at(H + C + 2, "play_again", 0, 1, 0, 2'b00, ls, rs);
      tick();
      left_win  = 1'b0;
      right_win = 1'b0;
      repeat (H + C + 1) tick();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; left_win = 1'b0; right_win = 1'b0;
    tick(); tick();
    expect_at(0, "reset_state", 1, 0, 0, 2'b00, 0, 0);
    reset = 1'b0;
    expect_at(1, "idle_hold", 1, 0, 0, 2'b00, 0, 0);
    tick();

    go_play();
    play_round(1'b1, 1'b0, 3'd1, 3'd0, 1'b0, 2'b00);
    play_round(1'b1, 1'b1, 3'd1, 3'd0, 1'b0, 2'b00);

    // Second left win, then reset two cycles into the countdown while start and a win also pulse.
    left_win = 1'b1;
    for (int i = 1; i <= H; i++) expect_at(i, "round_end_l2", 0, 0, 0, 2'b00, 2, 0);
    expect_at(H + 1, "clear_l2", 1, 0, 0, 2'b00, 2, 0);
    expect_at(H + 2, "cd_l2", 0, 0, 0, 2'b00, 2, 0);
    expect_at(H + 3, "cd_l2", 0, 0, 0, 2'b00, 2, 0);
    tick();
    left_win = 1'b0;
    repeat (H + 2) tick();
    reset = 1'b1; start = 1'b1; left_win = 1'b1;
    expect_at(1, "reset_mid_cd", 1, 0, 0, 2'b00, 0, 0);
    tick();
    reset = 1'b0; start = 1'b0; left_win = 1'b0;
    expect_at(1, "idle_after_rst", 1, 0, 0, 2'b00, 0, 0);
    tick();

    // Right player takes the match 3-0.
    go_play();
    play_round(1'b0, 1'b1, 3'd0, 3'd1, 1'b0, 2'b00);
    play_round(1'b0, 1'b1, 3'd0, 3'd2, 1'b0, 2'b00);
    play_round(1'b0, 1'b1, 3'd0, 3'd3, 1'b1, 2'b10);
    left_win = 1'b1; right_win = 1'b0;
    expect_at(1, "mo_ignore_l", 0, 0, 1, 2'b10, 0, 3);
    tick();
    left_win = 1'b0; right_win = 1'b1;
    expect_at(1, "mo_ignore_r", 0, 0, 1, 2'b10, 0, 3);
    tick();
    right_win = 1'b0; start = 1'b1;
    expect_at(1, "back_idle", 1, 0, 0, 2'b00, 0, 3);
    tick();
    start = 1'b0;
    expect_at(1, "idle_keeps_score", 1, 0, 0, 2'b00, 0, 3);
    tick();

    // Left player takes a match 3-1 with a tie in between.
    go_play();
    play_round(1'b1, 1'b0, 3'd1, 3'd0, 1'b0, 2'b00);
    play_round(1'b0, 1'b1, 3'd1, 3'd1, 1'b0, 2'b00);
    play_round(1'b1, 1'b1, 3'd1, 3'd1, 1'b0, 2'b00);
    play_round(1'b1, 1'b0, 3'd2, 3'd1, 1'b0, 2'b00);
    play_round(1'b1, 1'b0, 3'd3, 3'd1, 1'b1, 2'b01);
    expect_at(1, "mo_hold", 0, 0, 1, 2'b01, 3, 1);
    tick();

    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending checks want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
